// File: rtl/vpl_serial_addsub.sv
// vpl_serial_addsub: multi-cycle two's-complement adder/subtractor.
// Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first,
// with the carry held in a register between digits. A start/busy/done
// handshake frames each operation, which takes N = WIDTH/DIGIT RUN cycles.
// Subtraction is x + ~y + 1: the B operand is inverted at load time and the
// carry register is seeded with As_Sel.
// Optional build macro VPL_ADDSUB_SAT_EN: on signed overflow, s saturates to
// the most positive or most negative value (selected by the sign of x)
// instead of holding the wrapped sum. The interface is the same in both builds.
module vpl_serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             As_Sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   p_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [DIGIT:0]     dsum_c;
  logic               msb_cin_c;
  logic               ovf_c;
  logic [WIDTH-1:0]   p_next_c;
  logic [WIDTH-1:0]   res_c;

  // Digit adder, partial-result shift and final-result selection.
  // The carry into the digit MSB is recovered as sum ^ a ^ b at that bit, which
  // also covers DIGIT = 1, where it is simply the carry register.
  always_comb begin
    dsum_c    = (DIGIT+1)'(a_q[DIGIT-1:0]) + (DIGIT+1)'(b_q[DIGIT-1:0])
              + (DIGIT+1)'(carry_q);
    msb_cin_c = dsum_c[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    ovf_c     = msb_cin_c ^ dsum_c[DIGIT];
    p_next_c  = WIDTH'({dsum_c[DIGIT-1:0], p_q} >> DIGIT);
    res_c     = p_next_c;
`ifdef VPL_ADDSUB_SAT_EN
    // In the final digit a_q[DIGIT-1] is the sign bit of x.
    if (ovf_c) begin
      res_c = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM, operand shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= x;
            b_q     <= y ^ {WIDTH{As_Sel}};
            carry_q <= As_Sel;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          p_q     <= p_next_c;
          carry_q <= dsum_c[DIGIT];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            s     <= res_c;
            Cout  <= dsum_c[DIGIT];
            V     <= ovf_c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vpl_serial_addsub.sv
// Bench for vpl_serial_addsub: three instances (DIGIT = 4, 16, 1) sharing the
// operand buses, each with its own start. Expected results come from a
// full-width reference model and pass through a scoreboard queue.
module tb_vpl_serial_addsub;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [2:0]    start_v;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          sel;
  logic [2:0]    busy_v;
  logic [2:0]    done_v;
  logic [2:0]    cout_v;
  logic [2:0]    v_v;
  logic [W-1:0]  s0, s1, s2;

  int            checks;
  int            errors;
  exp_t          sb[$];
  logic [W-1:0]  last_s [3];

  vpl_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .x(x), .y(y), .As_Sel(sel),
    .busy(busy_v[0]), .done(done_v[0]), .s(s0), .Cout(cout_v[0]), .V(v_v[0]));

  vpl_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .x(x), .y(y), .As_Sel(sel),
    .busy(busy_v[1]), .done(done_v[1]), .s(s1), .Cout(cout_v[1]), .V(v_v[1]));

  vpl_serial_addsub #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .x(x), .y(y), .As_Sel(sel),
    .busy(busy_v[2]), .done(done_v[2]), .s(s2), .Cout(cout_v[2]), .V(v_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width add, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
`ifdef VPL_ADDSUB_SAT_EN
    if (e.v) e.s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] s_of(input int k);
    case (k)
      0:       return s0;
      1:       return s1;
      default: return s2;
    endcase
  endfunction

  function automatic int n_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge E0; waits for done, checks latency,
  // result stability during RUN, then the scoreboard entry and return to IDLE.
  task automatic wait_done(input int k);
    int   cyc;
    exp_t e;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (!done_v[k]) check("s_stable_run", 32'(s_of(k)), 32'(last_s[k]));
    end while (!done_v[k] && cyc < 40);
    check("latency", 32'(cyc), 32'(n_of(k)));
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      check("s", 32'(s_of(k)), 32'(e.s));
      check("cout", 32'(cout_v[k]), 32'(e.c));
      check("v", 32'(v_v[k]), 32'(e.v));
      last_s[k] = e.s;
    end
    check("busy_in_done", 32'(busy_v[k]), 32'(0));
    tick();
    check("done_pulse_end", 32'(done_v[k]), 32'(0));
    check("busy_idle", 32'(busy_v[k]), 32'(0));
  endtask

  task automatic do_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub);
    x = a;
    y = b;
    sel = sub;
    start_v[k] = 1'b1;
    sb.push_back(model(a, b, sub));
    tick();
    start_v[k] = 1'b0;
    check("busy_run", 32'(busy_v[k]), 32'(1));
    wait_done(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start_v = '0;
    x = '0;
    y = '0;
    sel = 1'b0;
    for (int k = 0; k < 3; k++) last_s[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    check("rst_busy", 32'(busy_v), 32'(0));
    check("rst_done", 32'(done_v), 32'(0));
    check("rst_cout", 32'(cout_v), 32'(0));
    check("rst_v", 32'(v_v), 32'(0));
    check("rst_s0", 32'(s0), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors on the DIGIT=4 instance.
    do_op(0, 16'h1234, 16'h0FFF, 1'b0);
    check("add_s_literal", 32'(s0), 32'h2233);
    do_op(0, 16'h0005, 16'h0007, 1'b1);
    check("sub_borrow_literal", 32'({s0, cout_v[0]}), 32'({16'hFFFE, 1'b0}));
    do_op(0, 16'h0007, 16'h0005, 1'b1);
    check("sub_noborrow_literal", 32'({s0, cout_v[0]}), 32'({16'h0002, 1'b1}));
    do_op(0, 16'h7FFF, 16'h0001, 1'b0);
`ifdef VPL_ADDSUB_SAT_EN
    check("ovf_literal", 32'({s0, v_v[0]}), 32'({16'h7FFF, 1'b1}));
`else
    check("ovf_literal", 32'({s0, v_v[0]}), 32'({16'h8000, 1'b1}));
`endif
    do_op(0, 16'hFFFF, 16'h0001, 1'b0);
    check("wrap_literal", 32'({s0, cout_v[0], v_v[0]}), 32'({16'h0000, 1'b1, 1'b0}));

    // Start held through RUN/DONE with changed operands: only accepted in IDLE.
    x = 16'h1111;
    y = 16'h2222;
    sel = 1'b0;
    start_v[0] = 1'b1;
    sb.push_back(model(16'h1111, 16'h2222, 1'b0));
    tick();
    x = 16'h0F0F;
    y = 16'h0101;
    wait_done(0);
    check("hs_first_result", 32'(s0), 32'h3333);
    sb.push_back(model(16'h0F0F, 16'h0101, 1'b0));
    tick();
    start_v[0] = 1'b0;
    check("hs_second_accept", 32'(busy_v[0]), 32'(1));
    wait_done(0);
    check("hs_second_result", 32'(s0), 32'h1010);

    // Reset asserted at E2 of an operation.
    x = 16'h1234;
    y = 16'h4321;
    sel = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_v[0]), 32'(0));
    check("midrst_s", 32'(s0), 32'(0));
    check("midrst_done", 32'(done_v[0]), 32'(0));
    for (int k = 0; k < 3; k++) last_s[k] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_done", 32'(done_v[0]), 32'(0));
    end
    do_op(0, 16'h1234, 16'h4321, 1'b0);

    // Parameter corners: DIGIT=16 (N=1) and DIGIT=1 (N=16).
    do_op(1, 16'h8000, 16'h0001, 1'b1);
    do_op(2, 16'h8000, 16'h0001, 1'b1);
`ifdef VPL_ADDSUB_SAT_EN
    check("corner_d16", 32'({s1, v_v[1]}), 32'({16'h8000, 1'b1}));
    check("corner_d1", 32'({s2, v_v[2]}), 32'({16'h8000, 1'b1}));
`else
    check("corner_d16", 32'({s1, v_v[1]}), 32'({16'h7FFF, 1'b1}));
    check("corner_d1", 32'({s2, v_v[2]}), 32'({16'h7FFF, 1'b1}));
`endif
    do_op(2, 16'h7FFF, 16'h0001, 1'b0);
    do_op(1, 16'hFFFF, 16'h0001, 1'b0);

    // Random operands across all three instances.
    for (int i = 0; i < 8; i++) begin
      do_op(i % 3, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
